// File: rtl/smem_result_pkg.sv
// smem_result_pkg: shared geometry, entry packing and drain FSM encoding
// for smem_result_buffer.
package smem_result_pkg;

    localparam int DATA_W   = 256;
    localparam int ENTRY_W  = 113;
    localparam int WIDE_W   = 33;
    localparam int NARROW_W = 7;

    // Field positions inside a 256-bit queue word
    localparam int F0_LO = 0;
    localparam int F1_LO = 64;
    localparam int F2_LO = 128;
    localparam int F3_LO = 192;
    localparam int F4_LO = 224;

    // Field positions inside a packed 113-bit entry
    localparam int E0_LO = 0;
    localparam int E1_LO = E0_LO + WIDE_W;
    localparam int E2_LO = E1_LO + WIDE_W;
    localparam int E3_LO = E2_LO + WIDE_W;
    localparam int E4_LO = E3_LO + NARROW_W;

    // Header beat field positions in lane 0
    localparam int HDR_SIZE_LO = 64;
    localparam int HDR_RET_LO  = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HDR,
        ST_DAT,
        ST_DONE
    } state_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [DATA_W-1:0] word);
        pack_entry = {word[F4_LO +: NARROW_W],
                      word[F3_LO +: NARROW_W],
                      word[F2_LO +: WIDE_W],
                      word[F1_LO +: WIDE_W],
                      word[F0_LO +: WIDE_W]};
    endfunction

    function automatic logic [DATA_W-1:0] unpack_entry(input logic [ENTRY_W-1:0] entry);
        unpack_entry = '0;
        unpack_entry[F0_LO +: WIDE_W]   = entry[E0_LO +: WIDE_W];
        unpack_entry[F1_LO +: WIDE_W]   = entry[E1_LO +: WIDE_W];
        unpack_entry[F2_LO +: WIDE_W]   = entry[E2_LO +: WIDE_W];
        unpack_entry[F3_LO +: NARROW_W] = entry[E3_LO +: NARROW_W];
        unpack_entry[F4_LO +: NARROW_W] = entry[E4_LO +: NARROW_W];
    endfunction

endpackage

// File: rtl/smem_queue_bank.sv
// smem_queue_bank: one packed queue RAM with a single write port and two
// registered read ports (host access and drain).
module smem_queue_bank
    import smem_result_pkg::*;
#(
    parameter int W     = ENTRY_W,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [W-1:0]  rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [W-1:0]  rdata_b_o
);

    logic [W-1:0] ram_q [DEPTH];
    logic [W-1:0] rdata_a_q;
    logic [W-1:0] rdata_b_q;

    // NOTE: the array itself is never reset so it can map onto block RAM;
    // only the read registers below return to zero.
    always_ff @(posedge clk) begin
        if (we_i) begin
            ram_q[waddr_i] <= wdata_i;
        end
    end

    // NOTE: non-blocking updates mean a read of the address being written
    // in the same cycle returns the word as it was before the write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= ram_q[raddr_a_i];
            rdata_b_q <= ram_q[raddr_b_i];
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/smem_result_buffer.sv
// smem_result_buffer: per-read curr/mem queue store that drains each read as a
// header beat plus LANES-wide data beats. SMEM_RESULT_RET_EN adds ret storage.
module smem_result_buffer
    import smem_result_pkg::*;
#(
    parameter int READ_W = 9,
    parameter int SLOTS  = 101,
    parameter int SLOT_W = 7,
    parameter int LANES  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [READ_W-1:0]       batch_size,
    input  logic                    curr_we,
    input  logic [READ_W-1:0]       curr_wnum,
    input  logic [SLOT_W-1:0]       curr_waddr,
    input  logic [DATA_W-1:0]       curr_wdata,
    input  logic [READ_W-1:0]       curr_rnum,
    input  logic [SLOT_W-1:0]       curr_raddr,
    output logic [DATA_W-1:0]       curr_rdata,
    input  logic                    mem_we,
    input  logic [READ_W-1:0]       mem_num,
    input  logic [SLOT_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W-1:0]       mem_rdata,
    input  logic                    size_valid,
    input  logic [READ_W-1:0]       size_num,
    input  logic [SLOT_W-1:0]       size,
    input  logic                    ret_valid,
    input  logic [READ_W-1:0]       ret_num,
    input  logic [SLOT_W-1:0]       ret,
    output logic                    out_request,
    input  logic                    out_permit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W*LANES-1:0] out_data,
    output logic                    out_last,
    output logic                    out_finish
);

    localparam int NREADS     = 1 << READ_W;
    localparam int ROWS       = (SLOTS + LANES - 1) / LANES;
    localparam int CURR_DEPTH = NREADS * SLOTS;
    localparam int CURR_AW    = $clog2(CURR_DEPTH);
    localparam int MEM_DEPTH  = NREADS * ROWS;
    localparam int MEM_AW     = $clog2(MEM_DEPTH);
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDX_W      = SLOT_W + 1;
    localparam logic [SLOT_W-1:0] SLOTS_MAX = SLOT_W'(SLOTS);

    // ------------------------------------------------------------------
    // curr queue
    // ------------------------------------------------------------------
    logic [CURR_AW-1:0] curr_waddr_flat;
    logic [CURR_AW-1:0] curr_raddr_flat;
    logic [ENTRY_W-1:0] curr_rd;
    logic [ENTRY_W-1:0] curr_unused_rd;

    assign curr_waddr_flat = CURR_AW'(curr_wnum) * CURR_AW'(SLOTS) + CURR_AW'(curr_waddr);
    assign curr_raddr_flat = CURR_AW'(curr_rnum) * CURR_AW'(SLOTS) + CURR_AW'(curr_raddr);

    smem_queue_bank #(
        .W     (ENTRY_W),
        .DEPTH (CURR_DEPTH),
        .AW    (CURR_AW)
    ) u_curr_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .we_i      (curr_we && (curr_waddr < SLOTS_MAX)),
        .waddr_i   (curr_waddr_flat),
        .wdata_i   (pack_entry(curr_wdata)),
        .raddr_a_i (curr_raddr_flat),
        .rdata_a_o (curr_rd),
        .raddr_b_i ('0),
        .rdata_b_o (curr_unused_rd)
    );

    assign curr_rdata = unpack_entry(curr_rd);

    // ------------------------------------------------------------------
    // mem queue: entry idx lives in bank (idx mod LANES), row (idx / LANES)
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [READ_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [LANE_W-1:0]  mem_lane;
    logic [LANE_W-1:0]  mem_lane_q;
    logic [MEM_AW-1:0]  mem_row_flat;
    logic [MEM_AW-1:0]  drain_row_flat;
    logic [ENTRY_W-1:0] host_rd  [LANES];
    logic [ENTRY_W-1:0] drain_rd [LANES];

    assign mem_lane       = LANE_W'(mem_addr % SLOT_W'(LANES));
    assign mem_row_flat   = MEM_AW'(mem_num) * MEM_AW'(ROWS) + MEM_AW'(mem_addr / SLOT_W'(LANES));
    // Drain reads follow the next state so the data beat is ready the cycle it is presented
    assign drain_row_flat = MEM_AW'(ptr_d) * MEM_AW'(ROWS) + MEM_AW'(idx_d / IDX_W'(LANES));

    for (genvar l = 0; l < LANES; l++) begin : g_mem_bank
        smem_queue_bank #(
            .W     (ENTRY_W),
            .DEPTH (MEM_DEPTH),
            .AW    (MEM_AW)
        ) u_mem_bank (
            .clk       (clk),
            .reset_n   (reset_n),
            .we_i      (mem_we && (mem_addr < SLOTS_MAX) && (mem_lane == LANE_W'(l))),
            .waddr_i   (mem_row_flat),
            .wdata_i   (pack_entry(mem_wdata)),
            .raddr_a_i (mem_row_flat),
            .rdata_a_o (host_rd[l]),
            .raddr_b_i (drain_row_flat),
            .rdata_b_o (drain_rd[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_lane_q <= '0;
        end else begin
            mem_lane_q <= mem_lane;
        end
    end

    assign mem_rdata = unpack_entry(host_rd[mem_lane_q]);

    // ------------------------------------------------------------------
    // Completion tracking, sizes and return codes
    // ------------------------------------------------------------------
    logic [NREADS-1:0]  done_map_q;
    logic [READ_W:0]    done_cnt_q;
    logic [SLOT_W-1:0]  size_mem [NREADS];
    logic [SLOT_W-1:0]  size_clamped;
    logic [SLOT_W-1:0]  hdr_ret;
    logic               batch_done;

    assign size_clamped = (size > SLOTS_MAX) ? SLOTS_MAX : size;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_map_q <= '0;
            done_cnt_q <= '0;
        end else if (size_valid && !done_map_q[size_num]) begin
            done_map_q[size_num] <= 1'b1;
            done_cnt_q           <= done_cnt_q + (READ_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (size_valid) begin
            size_mem[size_num] <= size_clamped;
        end
    end

    assign batch_done = (done_cnt_q == {1'b0, batch_size}) && (batch_size != '0);

`ifdef SMEM_RESULT_RET_EN
    logic [SLOT_W-1:0] ret_mem [NREADS];

    always_ff @(posedge clk) begin
        if (ret_valid) begin
            ret_mem[ret_num] <= ret;
        end
    end

    assign hdr_ret = ret_mem[ptr_q];
`else
    logic unused_ret;

    assign unused_ret = ^{ret_valid, ret_num, ret};
    assign hdr_ret    = '0;
`endif

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0] cur_size;
    logic              presenting;
    logic              beat_acc;
    logic              grp_end;
    logic              last_read;

    assign cur_size   = size_mem[ptr_q];
    assign presenting = (state_q == ST_HDR) || (state_q == ST_DAT);
    assign beat_acc   = presenting && out_permit && out_ready;
    assign last_read  = (ptr_q == batch_size - READ_W'(1));
    assign grp_end    = (state_q == ST_HDR) ? (cur_size == '0)
                                            : (idx_q + IDX_W'(LANES) >= IDX_W'(cur_size));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (batch_done) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (out_permit) begin
                    state_d = ST_HDR;
                    ptr_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_HDR, ST_DAT: begin
                if (beat_acc) begin
                    if (!grp_end && (state_q == ST_HDR)) begin
                        state_d = ST_DAT;
                        idx_d   = '0;
                    end else if (!grp_end) begin
                        idx_d = idx_q + IDX_W'(LANES);
                    end else if (last_read) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_HDR;
                        ptr_d   = ptr_q + READ_W'(1);
                        idx_d   = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        out_request = (state_q != ST_IDLE);
        out_valid   = presenting && out_permit;
        out_last    = presenting && grp_end;
        out_finish  = (state_q == ST_DONE);
        out_data    = '0;
        if (state_q == ST_HDR) begin
            out_data[READ_W-1:0]            = ptr_q;
            out_data[HDR_SIZE_LO +: SLOT_W] = cur_size;
            out_data[HDR_RET_LO +: SLOT_W]  = hdr_ret;
        end else if (state_q == ST_DAT) begin
            // Lanes past the end of the read stay zero
            for (int l = 0; l < LANES; l++) begin
                if (idx_q + IDX_W'(l) < IDX_W'(cur_size)) begin
                    out_data[l*DATA_W +: DATA_W] = unpack_entry(drain_rd[l]);
                end
            end
        end
    end

endmodule

// File: doc/smem_result_buffer.md
# smem_result_buffer

Per-read result store for the SMEM pipeline: holds a batch's curr/mem interval queues, per-read mem sizes and return codes, then drains each read as a header beat plus LANES packed mem entries per beat over a valid/ready stream. It replaces the fixed 512×101, two-entry-per-beat, stall-driven result buffer. Geometry, lane count and stream backpressure are now parametrised, and groups are emitted back-to-back with no idle gap.

## Interface
- READ_W, 9: read-number width; batch capacity 2^READ_W reads
- SLOTS, 101: queue slots per read per queue
- SLOT_W, 7: slot address / size width, must satisfy 2^SLOT_W > SLOTS
- LANES, 2: mem entries per output beat, 1..4
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- batch_size  in  READ_W  reads in batch, sampled each cycle, held stable per batch
- curr_we, curr_wnum, curr_waddr, curr_wdata  in  1/READ_W/SLOT_W/256  curr write port
- curr_rnum, curr_raddr  in  READ_W/SLOT_W  curr read address; curr_rdata out 256, 1-cycle latency
- mem_we, mem_num, mem_addr, mem_wdata  in  1/READ_W/SLOT_W/256  mem port; mem_rdata out 256, reads [mem_num][mem_addr], 1-cycle latency
- size_valid, size_num, size  in  1/READ_W/SLOT_W  final mem size of a read
- ret_valid, ret_num, ret  in  1/READ_W/SLOT_W  return code of a read
- out_request  out  1  batch complete, requesting the output bus
- out_permit  in  1  bus granted, level
- out_valid/out_ready  out/in  1/1  stream handshake
- out_data  out  256*LANES  beat payload
- out_last  out  1  final beat of a read's group
- out_finish  out  1  whole batch drained, sticky

## Operation
- Entry packing (113 b stored): fields [32:0], [96:64], [160:128], [198:192], [230:224] of a 256-bit word. Unstored bits read back as 0.
- Write and read on the same cycle and same address: read returns the old data.
- Completion tracking:
  - Per-read done bitmap. size_valid on an unset bit sets the bit and increments done_cnt.
  - A repeated size_valid for the same read overwrites the stored size but does not count again.
  - batch_done = (done_cnt == batch_size) && batch_size != 0.
- FSM:
  - IDLE -> REQ on batch_done; out_request = 1 in REQ and in every later state until reset.
  - REQ -> HDR when out_permit = 1.
  - HDR drives one header beat for read ptr. Lane 0: [READ_W-1:0] = ptr, [64+SLOT_W-1:64] = size, [128+SLOT_W-1:128] = ret. All other bits 0.
    - On accept: if size == 0, assert out_last and go to the next read; otherwise go to DAT with idx = 0.
  - DAT: beat carries entries idx..idx+LANES-1 in lanes 0..LANES-1. Lanes at or beyond size are all-zero. out_last is set on the beat where idx+LANES >= size.
    - On accept: idx += LANES, or advance ptr and go to HDR.
  - Advancing ptr from batch_size-1 -> DONE: out_valid = 0, out_finish = 1.
- out_permit deasserted:
  - Outside an accepted handshake, the FSM freezes and out_valid drops. A pending beat is re-presented unchanged when permit returns.
  - A beat already presented is never altered while out_valid && !out_ready.
- Each mem RAM has a dedicated internal drain read port. LANES entries are fetched in parallel via LANES banks, with entries interleaved by idx mod LANES.

## Timing
- Reset values: out_request 0, out_valid 0, out_data 0, out_last 0, out_finish 0, curr_rdata 0, mem_rdata 0, done_cnt 0, bitmap clear, ptr 0, FSM IDLE.
- Reset mid-drain returns to IDLE in one cycle. Queue contents are not cleared.
- size_valid on cycle N: batch_done on N+1, out_request on N+2.
- out_permit high on cycle M: first header out_valid on M+1 (prefetch overlaps).
- Steady state with out_ready = 1: one beat per cycle, including group boundaries, with no bubble.
- Arithmetic:
  - idx is SLOT_W+1 bits to avoid wrap at SLOTS.
  - size > SLOTS is clamped to SLOTS.

## Configuration
- SMEM_RESULT_RET_EN defined: ret storage and the header ret field are present.
- Without it: ret_* inputs are ignored, no ret RAM is inferred, and header bits [159:128] are 0.

## Structure
- Package smem_result_pkg:
  - ENTRY_W = 113
  - field-offset localparams
  - pack_entry / unpack_entry functions
  - FSM state enum
- Sub-module smem_queue_bank: one packed queue RAM with one write port and two synchronous read ports. Instantiated for curr, and LANES times for mem.

## Test plan
- batch_size = 3, sizes {2, 0, 5}, LANES = 2, out_ready = 1 -> beats H0, D(e0, e1)L, H1L, H2, D(e0, e1), D(e2, e3), D(e4, 0)L. No gaps; out_finish high after the 7th beat.
- Same stimulus with out_ready toggling 1010… -> identical beat sequence. out_data is stable across every stalled cycle.
- size_valid sent twice for read 1 (values 4 then 3), batch_size = 2 -> out_request is withheld until read 0 reports. Header 1 shows size 3.
- Drop out_permit mid-DAT for 5 cycles -> out_valid low during the drop. The same beat resumes and no entry is lost or duplicated.
- mem write and mem read to the same [num][addr] in one cycle -> mem_rdata shows old data; the next cycle shows new data. Unstored bits are 0.
- Without SMEM_RESULT_RET_EN, ret_valid with ret = 7 -> header [159:128] = 0.
